branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Successor to the branch-decision logic: resolves 8 branch types in EX and holds a BHT of
//  2-bit saturating counters, giving IF a taken/not-taken prediction. Compares each resolved
//  branch with the prediction carried down the pipeline and raises a registered one-cycle
//  mispredict pulse for the flush/redirect logic. Also keeps saturating branch/miss counters.
// PARAMETERS
//  DATA_W      32  width of result_i
//  ADDR_W      32  PC width
//  BHT_ENTRIES 16  counter count, power of 2, >=2; IDX_W = log2(BHT_ENTRIES)
//  CNT_INIT    1   counter reset value (0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T)
//  STAT_W      16  width of the statistics counters
// PORTS
//  clk_i          in   1       clock, rising edge
//  rst_i          in   1       asynchronous reset, active-high
//  pred_pc_i      in   ADDR_W  IF-stage PC to predict
//  pred_taken_o   out  1       prediction for pred_pc_i (combinational)
//  res_valid_i    in   1       EX holds a branch this cycle
//  res_pc_i       in   ADDR_W  PC of the resolving branch
//  BranchType_i   in   3       branch type code, see BEHAVIOUR
//  zero_i         in   1       ALU zero flag
//  result_i       in   DATA_W  ALU result, signed (rs - rt, or rs for the z-forms)
//  pred_taken_i   in   1       prediction made for this branch in IF
//  res_taken_o    out  1       registered actual outcome of last accepted branch
//  mispredict_o   out  1       registered one-cycle pulse: flush and redirect
//  br_count_o     out  STAT_W  accepted branches, saturating
//  miss_count_o   out  STAT_W  mispredicts, saturating
// BEHAVIOUR
//  - Reset (async, immediate): all BHT counters = CNT_INIT. res_taken_o, mispredict_o,
//    br_count_o and miss_count_o = 0. pred_taken_o follows CNT_INIT[1] during reset.
//  - Index = pc[IDX_W+1:2]. Word-aligned; bits [1:0] ignored.
//  - pred_taken_o = BHT[idx(pred_pc_i)][1]. Purely combinational, zero latency.
//  - Actual outcome, combinational, with signed result_i:
//      0 beq: zero_i
//      1 bne: !zero_i
//      2 ble: result_i <= 0
//      3 bltz: result_i < 0
//      4 bgez: result_i >= 0
//      5 bgtz: result_i > 0
//      6 always: 1
//      7 never: 0
//  - Accept = res_valid_i && !mispredict_o. A branch in the cycle mispredict_o is high is
//    wrong-path: no BHT update, no counts, and res_taken_o/mispredict_o go to 0 next cycle.
//  - On the accepting edge:
//      res_taken_o  <= taken
//      mispredict_o <= (taken != pred_taken_i)
//      BHT[idx(res_pc_i)] +1 if taken, -1 if not, saturating at 3 and 0
//      br_count_o +1 and, on mispredict, miss_count_o +1; both hold at all-ones
//  - No accept: mispredict_o <= 0 and res_taken_o <= 0. The output latency is 1 cycle.
//  - Same index read and written in one cycle: pred_taken_o shows the old value; the new
//    value is visible the next cycle. There is no bypass.
//  - Back-to-back accepted branches to the same index update twice, one step per edge.
//  - Reset mid-flush: mispredict_o drops at once and the counters are restored.
// TESTING
//  1 After reset, CNT_INIT=1: pred_taken_o=0 for any PC. Counts and pulses read 0.
//  2 PC 0x40, type 0, zero_i=1, pred_taken_i=0 -> next cycle res_taken_o=1,
//    mispredict_o=1, miss_count_o=1. One cycle later mispredict_o=0 and
//    pred_taken_o(0x40)=1.
//  3 Type 5, result_i=0x8000_0000 -> not taken. Type 2, result_i=0 -> taken.
//    Type 4, result_i=0 -> taken. Type 6 always taken, type 7 never taken.
//  4 Four taken at PC 0x44: counter saturates at 3. Then one not-taken: pred stays 1.
//    Then a second not-taken: pred becomes 0. PC 0x84 aliases 0x44 at 16 entries.
//  5 res_valid_i in the cycle after a mispredict -> ignored: no BHT change, no count.
//  6 With STAT_W=4: 20 accepted branches -> br_count_o=15. Assert rst_i while
//    mispredict_o=1 -> it clears at once, before the next edge.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch resolution plus a BHT of 2-bit saturating counters for IF prediction.
// Raises a registered one-cycle mispredict pulse and keeps saturating branch/miss counts.

module bpu_bht_ctr #(
    parameter logic [1:0] INIT = 2'd1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       upd_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);
    logic [1:0] ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (upd_i) begin
            if (taken_i && (ctr_q != 2'd3))
                ctr_d = ctr_q + 2'd1;
            else if (!taken_i && (ctr_q != 2'd0))
                ctr_d = ctr_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ctr_q <= INIT;
        else       ctr_q <= ctr_d;
    end

    assign ctr_o = ctr_q;
endmodule

module branch_predict_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_INIT    = 1,
    parameter int STAT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pred_pc_i,
    output logic              pred_taken_o,
    input  logic              res_valid_i,
    input  logic [ADDR_W-1:0] res_pc_i,
    input  logic [2:0]        BranchType_i,
    input  logic              zero_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic              pred_taken_i,
    output logic              res_taken_o,
    output logic              mispredict_o,
    output logic [STAT_W-1:0] br_count_o,
    output logic [STAT_W-1:0] miss_count_o
);
    localparam int         IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [1:0] INIT2 = 2'(CNT_INIT);

    logic [BHT_ENTRIES-1:0][1:0] bht;
    logic [IDX_W-1:0]            pred_idx, res_idx;
    logic                        taken, accept;
    logic                        res_neg, res_zero;
    logic                        res_taken_q, res_taken_d;
    logic                        mispred_q, mispred_d;
    logic [STAT_W-1:0]           br_cnt_q, br_cnt_d;
    logic [STAT_W-1:0]           miss_cnt_q, miss_cnt_d;
    logic                        unused_pc;

    // Word-aligned PCs: the low two bits never select an entry.
    assign pred_idx  = pred_pc_i[IDX_W+1:2];
    assign res_idx   = res_pc_i[IDX_W+1:2];
    assign unused_pc = ^{pred_pc_i, res_pc_i};

    // No bypass: a same-cycle update shows up at IF one cycle later.
    assign pred_taken_o = bht[pred_idx][1];

    assign res_neg  = result_i[DATA_W-1];
    assign res_zero = (result_i == '0);

    always_comb begin
        taken = 1'b0;
        unique case (BranchType_i)
            3'd0: taken = zero_i;
            3'd1: taken = !zero_i;
            3'd2: taken = res_neg || res_zero;
            3'd3: taken = res_neg;
            3'd4: taken = !res_neg;
            3'd5: taken = !res_neg && !res_zero;
            3'd6: taken = 1'b1;
            3'd7: taken = 1'b0;
        endcase
    end

    // The branch arriving during a flush pulse is on the wrong path.
    assign accept = res_valid_i && !mispred_q;

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        bpu_bht_ctr #(.INIT(INIT2)) u_ctr (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .upd_i   (accept && (res_idx == IDX_W'(i))),
            .taken_i (taken),
            .ctr_o   (bht[i])
        );
    end

    always_comb begin
        res_taken_d = 1'b0;
        mispred_d   = 1'b0;
        br_cnt_d    = br_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (accept) begin
            res_taken_d = taken;
            mispred_d   = (taken != pred_taken_i);
            if (br_cnt_q != '1)
                br_cnt_d = br_cnt_q + 1'b1;
            if (mispred_d && (miss_cnt_q != '1))
                miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_taken_q <= 1'b0;
            mispred_q   <= 1'b0;
            br_cnt_q    <= '0;
            miss_cnt_q  <= '0;
        end else begin
            res_taken_q <= res_taken_d;
            mispred_q   <= mispred_d;
            br_cnt_q    <= br_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign res_taken_o  = res_taken_q;
    assign mispredict_o = mispred_q;
    assign br_count_o   = br_cnt_q;
    assign miss_count_o = miss_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (16 entries, CNT_INIT=1, STAT_W=4).
module tb_branch_predict_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pred_pc_i = '0;
    logic        pred_taken_o;
    logic        res_valid_i = 1'b0;
    logic [31:0] res_pc_i = '0;
    logic [2:0]  BranchType_i = '0;
    logic        zero_i = 1'b0;
    logic [31:0] result_i = '0;
    logic        pred_taken_i = 1'b0;
    logic        res_taken_o;
    logic        mispredict_o;
    logic [3:0]  br_count_o;
    logic [3:0]  miss_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predict_unit #(
        .DATA_W(32), .ADDR_W(32), .BHT_ENTRIES(16), .CNT_INIT(1), .STAT_W(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pred_pc_i(pred_pc_i), .pred_taken_o(pred_taken_o),
        .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .BranchType_i(BranchType_i),
        .zero_i(zero_i), .result_i(result_i), .pred_taken_i(pred_taken_i),
        .res_taken_o(res_taken_o), .mispredict_o(mispredict_o),
        .br_count_o(br_count_o), .miss_count_o(miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one resolving branch across a rising edge; outputs settle 1ns later.
    task automatic br(input logic [31:0] pc, input logic [2:0] ty, input logic z,
                      input logic [31:0] res, input logic pt);
        res_pc_i     = pc;
        BranchType_i = ty;
        zero_i       = z;
        result_i     = res;
        pred_taken_i = pt;
        res_valid_i  = 1'b1;
        @(posedge clk_i); #1;
        res_valid_i  = 1'b0;
    endtask

    task automatic idle();
        res_valid_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc, input logic exp);
        pred_pc_i = pc;
        #1;
        check(tag, {31'd0, pred_taken_o}, {31'd0, exp});
    endtask

    initial begin
        // Reset state
        #3;
        pred_at("rst_pred_40", 32'h40, 1'b0);
        pred_at("rst_pred_7c", 32'h7c, 1'b0);
        check("rst_res_taken", {31'd0, res_taken_o}, 32'd0);
        check("rst_mispred", {31'd0, mispredict_o}, 32'd0);
        check("rst_br_cnt", {28'd0, br_count_o}, 32'd0);
        check("rst_miss_cnt", {28'd0, miss_count_o}, 32'd0);
        @(negedge clk_i); rst_i = 1'b0;

        // beq taken, predicted not-taken -> mispredict
        br(32'h40, 3'd0, 1'b1, 32'd0, 1'b0);
        check("beq_res_taken", {31'd0, res_taken_o}, 32'd1);
        check("beq_mispred", {31'd0, mispredict_o}, 32'd1);
        check("beq_miss_cnt", {28'd0, miss_count_o}, 32'd1);
        check("beq_br_cnt", {28'd0, br_count_o}, 32'd1);
        idle();
        check("idle_mispred", {31'd0, mispredict_o}, 32'd0);
        check("idle_res_taken", {31'd0, res_taken_o}, 32'd0);
        pred_at("pred_40_after", 32'h40, 1'b1);

        // Outcome decode at PC 0x48; predictions match so no flush.
        br(32'h48, 3'd5, 1'b0, 32'h8000_0000, 1'b0);
        check("bgtz_neg", {31'd0, res_taken_o}, 32'd0);
        br(32'h48, 3'd2, 1'b0, 32'd0, 1'b1);
        check("ble_zero", {31'd0, res_taken_o}, 32'd1);
        br(32'h48, 3'd4, 1'b0, 32'd0, 1'b1);
        check("bgez_zero", {31'd0, res_taken_o}, 32'd1);
        br(32'h48, 3'd6, 1'b0, 32'd0, 1'b1);
        check("always", {31'd0, res_taken_o}, 32'd1);
        br(32'h48, 3'd7, 1'b1, 32'hffff_ffff, 1'b0);
        check("never", {31'd0, res_taken_o}, 32'd0);
        br(32'h48, 3'd1, 1'b0, 32'd5, 1'b1);
        check("bne_nz", {31'd0, res_taken_o}, 32'd1);
        br(32'h48, 3'd3, 1'b0, 32'hffff_ffff, 1'b1);
        check("bltz_neg", {31'd0, res_taken_o}, 32'd1);
        check("bltz_mispred", {31'd0, mispredict_o}, 32'd0);
        br(32'h48, 3'd5, 1'b0, 32'd5, 1'b1);
        check("bgtz_pos", {31'd0, res_taken_o}, 32'd1);
        br(32'h48, 3'd2, 1'b0, 32'd1, 1'b0);
        check("ble_pos", {31'd0, res_taken_o}, 32'd0);
        check("decode_br_cnt", {28'd0, br_count_o}, 32'd10);
        check("decode_miss_cnt", {28'd0, miss_count_o}, 32'd1);

        // Wrong-path branch right after a mispredict is dropped.
        br(32'h4c, 3'd6, 1'b0, 32'd0, 1'b0);
        check("wp_first_mispred", {31'd0, mispredict_o}, 32'd1);
        br(32'h4c, 3'd6, 1'b0, 32'd0, 1'b0);
        check("wp_mispred", {31'd0, mispredict_o}, 32'd0);
        check("wp_res_taken", {31'd0, res_taken_o}, 32'd0);
        check("wp_br_cnt", {28'd0, br_count_o}, 32'd11);
        check("wp_miss_cnt", {28'd0, miss_count_o}, 32'd2);
        br(32'h4c, 3'd7, 1'b0, 32'd0, 1'b1);
        check("wp_nt_mispred", {31'd0, mispredict_o}, 32'd1);
        idle();
        pred_at("wp_pred_4c", 32'h4c, 1'b0);
        check("wp_miss_cnt2", {28'd0, miss_count_o}, 32'd3);

        // Saturation at 3 on PC 0x44, with same-cycle read showing the old value.
        pred_pc_i = 32'h44;
        res_pc_i = 32'h44; BranchType_i = 3'd6; res_valid_i = 1'b1; pred_taken_i = 1'b1;
        #1;
        check("nobypass_old", {31'd0, pred_taken_o}, 32'd0);
        br(32'h44, 3'd6, 1'b0, 32'd0, 1'b1);
        check("nobypass_new", {31'd0, pred_taken_o}, 32'd1);
        br(32'h44, 3'd6, 1'b0, 32'd0, 1'b1);
        br(32'h44, 3'd6, 1'b0, 32'd0, 1'b1);
        br(32'h44, 3'd6, 1'b0, 32'd0, 1'b1);
        check("sat_br_cnt", {28'd0, br_count_o}, 32'd15);
        br(32'h44, 3'd7, 1'b0, 32'd0, 1'b0);
        pred_at("sat_nt1_44", 32'h44, 1'b1);
        pred_at("alias_84_a", 32'h84, 1'b1);
        br(32'h44, 3'd7, 1'b0, 32'd0, 1'b0);
        pred_at("sat_nt2_44", 32'h44, 1'b0);
        pred_at("alias_84_b", 32'h84, 1'b0);

        // Saturation at 0 on PC 0x58, plus filler to exceed 20 accepted branches.
        br(32'h58, 3'd7, 1'b0, 32'd0, 1'b0);
        br(32'h58, 3'd7, 1'b0, 32'd0, 1'b0);
        br(32'h58, 3'd6, 1'b0, 32'd0, 1'b1);
        pred_at("sat0_58", 32'h58, 1'b0);
        for (int i = 0; i < 3; i++) br(32'h60, 3'd6, 1'b0, 32'd0, 1'b1);
        check("stat_sat_br", {28'd0, br_count_o}, 32'd15);
        check("stat_miss", {28'd0, miss_count_o}, 32'd3);

        // Async reset during a flush pulse.
        br(32'h50, 3'd0, 1'b1, 32'd0, 1'b0);
        check("flush_pulse", {31'd0, mispredict_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_mid_mispred", {31'd0, mispredict_o}, 32'd0);
        check("rst_mid_br_cnt", {28'd0, br_count_o}, 32'd0);
        check("rst_mid_miss_cnt", {28'd0, miss_count_o}, 32'd0);
        pred_at("rst_mid_pred_40", 32'h40, 1'b0);
        pred_at("rst_mid_pred_44", 32'h44, 1'b0);
        @(negedge clk_i); rst_i = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
